// File: rtl/lsu_vec.sv
`default_nettype none
// ============================================================================
// Module   : lsu_vec
// Purpose  : Per-thread vector load-store unit for the Q1.15 GPU core.
//            Executes LDR/STR as a burst of 1..MAX_VEC consecutive words
//            over a valid/ready data-memory port, with a per-beat response
//            watchdog that aborts a stalled access and raises lsu_error.
// Ports    : clk, reset (async, active-high), enable (thread active)
//            core_state            scheduler state (REQUEST / UPDATE)
//            decoded_mem_*_enable  LDR / STR in flight
//            decoded_vec_len       words per access (0 -> 1, clamp MAX_VEC)
//            rs                    base address (low ADDR_BITS used)
//            rt                    packed store data, word i at i*DATA_BITS
//            mem_read_*            read request / response channel
//            mem_write_*           write request / acknowledge channel
//            lsu_state             IDLE / REQUESTING / WAITING / DONE
//            lsu_out               packed loaded words
//            lsu_error             last access aborted by the watchdog
// Revision : 1.0 - initial release
// ============================================================================
module lsu_vec #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int MAX_VEC        = 4,
    parameter int LEN_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [2:0]                     core_state,
    input  logic                           decoded_mem_read_enable,
    input  logic                           decoded_mem_write_enable,
    input  logic [LEN_BITS-1:0]            decoded_vec_len,
    input  logic [DATA_BITS-1:0]           rs,
    input  logic [MAX_VEC*DATA_BITS-1:0]   rt,
    output logic                           mem_read_valid,
    output logic [ADDR_BITS-1:0]           mem_read_address,
    input  logic                           mem_read_ready,
    input  logic [DATA_BITS-1:0]           mem_read_data,
    output logic                           mem_write_valid,
    output logic [ADDR_BITS-1:0]           mem_write_address,
    output logic [DATA_BITS-1:0]           mem_write_data,
    input  logic                           mem_write_ready,
    output logic [1:0]                     lsu_state,
    output logic [MAX_VEC*DATA_BITS-1:0]   lsu_out,
    output logic                           lsu_error
);

    localparam int IDX_W = (MAX_VEC > 1) ? $clog2(MAX_VEC) : 1;
    // The watchdog only has to reach TIMEOUT_CYCLES-1.
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] c_core_request = 3'b011;
    localparam logic [2:0] c_core_update  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_REQUESTING = 2'b01,
        ST_WAITING    = 2'b10,
        ST_DONE       = 2'b11
    } state_t;

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_base;
    logic [IDX_W-1:0]     r_last;      // index of the final beat (len-1)
    logic [IDX_W-1:0]     r_beat;
    logic                 r_is_read;
    logic [WD_W-1:0]      r_wd;

    logic [31:0]          w_len_req;
    logic [IDX_W-1:0]     w_last_new;
    logic [DATA_BITS-1:0] w_store_word;
    logic [ADDR_BITS-1:0] w_addr;
    logic                 w_start;
    logic                 w_ready;
    logic                 w_wd_expire;

    assign lsu_state = r_state;

    // Length 0 is a single word; anything beyond MAX_VEC is clamped.
    always_comb begin
        w_len_req = 32'(decoded_vec_len);
        if (w_len_req == 32'd0) begin
            w_last_new = '0;
        end else if (w_len_req > 32'(MAX_VEC)) begin
            w_last_new = IDX_W'(MAX_VEC - 1);
        end else begin
            w_last_new = IDX_W'(w_len_req - 32'd1);
        end
    end

    always_comb begin
        w_store_word = rt[DATA_BITS-1:0];
        for (int i = 0; i < MAX_VEC; i++) begin
            if (r_beat == IDX_W'(i)) begin
                w_store_word = rt[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Address arithmetic deliberately wraps modulo 2^ADDR_BITS.
    assign w_addr      = r_base + ADDR_BITS'(r_beat);
    assign w_start     = (core_state == c_core_request) &&
                         (decoded_mem_read_enable || decoded_mem_write_enable);
    assign w_ready     = r_is_read ? mem_read_ready : mem_write_ready;
    assign w_wd_expire = (TIMEOUT_CYCLES != 0) &&
                         (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    // Only the low ADDR_BITS of rs form the address.
    generate
        if (DATA_BITS > ADDR_BITS) begin : g_rs_unused
            logic w_unused_rs;
            assign w_unused_rs = ^rs[DATA_BITS-1:ADDR_BITS];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_base            <= '0;
            r_last            <= '0;
            r_beat            <= '0;
            r_is_read         <= 1'b0;
            r_wd              <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
            lsu_error         <= 1'b0;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_base    <= rs[ADDR_BITS-1:0];
                        r_last    <= w_last_new;
                        r_is_read <= decoded_mem_read_enable;  // read wins
                        r_beat    <= '0;
                        lsu_error <= 1'b0;
                        r_state   <= ST_REQUESTING;
                    end
                end

                ST_REQUESTING: begin
                    r_wd <= '0;
                    if (r_is_read) begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= w_addr;
                    end else begin
                        mem_write_valid   <= 1'b1;
                        mem_write_address <= w_addr;
                        mem_write_data    <= w_store_word;
                    end
                    r_state <= ST_WAITING;
                end

                ST_WAITING: begin
                    if (w_ready) begin
                        mem_read_valid  <= 1'b0;
                        mem_write_valid <= 1'b0;
                        if (r_is_read) begin
                            for (int i = 0; i < MAX_VEC; i++) begin
                                if (r_beat == IDX_W'(i)) begin
                                    lsu_out[i*DATA_BITS +: DATA_BITS] <= mem_read_data;
                                end
                            end
                        end
                        r_beat  <= r_beat + 1'b1;
                        r_state <= (r_beat == r_last) ? ST_DONE : ST_REQUESTING;
                    end else if (w_wd_expire) begin
                        // Abandon this and all remaining beats.
                        mem_read_valid  <= 1'b0;
                        mem_write_valid <= 1'b0;
                        lsu_error       <= 1'b1;
                        r_state         <= ST_DONE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (core_state == c_core_update) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_vec.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_vec
// Purpose  : Directed self-checking bench for lsu_vec (MAX_VEC=4,
//            TIMEOUT_CYCLES=8). Inputs change and outputs are checked just
//            after the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_vec;

    localparam int ADDR_BITS      = 8;
    localparam int DATA_BITS      = 16;
    localparam int MAX_VEC        = 4;
    localparam int LEN_BITS       = 4;
    localparam int TIMEOUT_CYCLES = 8;

    localparam logic [2:0] c_core_request = 3'b011;
    localparam logic [2:0] c_core_update  = 3'b110;
    localparam logic [2:0] c_core_other   = 3'b000;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         enable;
    logic [2:0]                   core_state;
    logic                         decoded_mem_read_enable;
    logic                         decoded_mem_write_enable;
    logic [LEN_BITS-1:0]          decoded_vec_len;
    logic [DATA_BITS-1:0]         rs;
    logic [MAX_VEC*DATA_BITS-1:0] rt;
    logic                         mem_read_valid;
    logic [ADDR_BITS-1:0]         mem_read_address;
    logic                         mem_read_ready;
    logic [DATA_BITS-1:0]         mem_read_data;
    logic                         mem_write_valid;
    logic [ADDR_BITS-1:0]         mem_write_address;
    logic [DATA_BITS-1:0]         mem_write_data;
    logic                         mem_write_ready;
    logic [1:0]                   lsu_state;
    logic [MAX_VEC*DATA_BITS-1:0] lsu_out;
    logic                         lsu_error;

    int total = 0;
    int bad   = 0;
    int beats;

    logic [7:0]  exp_waddr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [15:0] exp_wdata [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    always #5 clk = ~clk;

    lsu_vec #(
        .ADDR_BITS      (ADDR_BITS),
        .DATA_BITS      (DATA_BITS),
        .MAX_VEC        (MAX_VEC),
        .LEN_BITS       (LEN_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .decoded_vec_len          (decoded_vec_len),
        .rs                       (rs),
        .rt                       (rt),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .lsu_error                (lsu_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Memory model: read data is 0xA0 followed by the requested address.
    task automatic model_data();
        mem_read_data = {8'hA0, mem_read_address};
    endtask

    task automatic finish_access(input string tag);
        core_state = c_core_update;
        step();
        chk(tag, 64'(lsu_state), 64'd0);
        core_state               = c_core_other;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        mem_read_ready           = 1'b0;
        mem_write_ready          = 1'b0;
    endtask

    // Read burst with ready held high; counts request beats until DONE.
    task automatic run_read(input logic [3:0] len, input logic [15:0] base,
                            input string tag, output int nbeats);
        decoded_mem_read_enable  = 1'b1;
        decoded_mem_write_enable = 1'b0;
        decoded_vec_len          = len;
        rs                       = base;
        mem_read_ready           = 1'b1;
        core_state               = c_core_request;
        step();
        core_state = c_core_other;
        nbeats = 0;
        for (int c = 0; c < 40 && lsu_state != 2'b11; c++) begin
            model_data();
            step();
            if (mem_read_valid) nbeats++;
        end
        chk(tag, 64'(lsu_state), 64'd3);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset                    = 1'b1;
        enable                   = 1'b1;
        core_state               = c_core_other;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        decoded_vec_len          = '0;
        rs                       = '0;
        rt                       = '0;
        mem_read_ready           = 1'b0;
        mem_read_data            = '0;
        mem_write_ready          = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_state",  64'(lsu_state), 64'd0);
        chk("rst_rvalid", 64'(mem_read_valid), 64'd0);
        chk("rst_wvalid", 64'(mem_write_valid), 64'd0);
        chk("rst_out",    lsu_out, 64'd0);
        chk("rst_err",    64'(lsu_error), 64'd0);
        chk("rst_waddr",  64'(mem_write_address), 64'd0);
        reset = 1'b0;
        step();

        // ---------------- single read ----------------
        decoded_mem_read_enable = 1'b1;
        decoded_vec_len         = 4'd1;
        rs                      = 16'h0010;
        mem_read_ready          = 1'b1;
        mem_read_data           = 16'h4000;
        core_state              = c_core_request;
        step();                                   // edge 0
        chk("r1_state_req", 64'(lsu_state), 64'd1);
        core_state = c_core_other;
        step();                                   // edge 1
        chk("r1_rvalid", 64'(mem_read_valid), 64'd1);
        chk("r1_raddr",  64'(mem_read_address), 64'h10);
        step();                                   // edge 2
        chk("r1_rvalid_drop", 64'(mem_read_valid), 64'd0);
        step();                                   // edge 3
        chk("r1_done", 64'(lsu_state), 64'd3);
        chk("r1_out",  lsu_out, 64'h0000_0000_0000_4000);
        chk("r1_err",  64'(lsu_error), 64'd0);
        finish_access("r1_idle");

        // ---------------- vector write with address wrap ----------------
        decoded_mem_write_enable = 1'b1;
        decoded_vec_len          = 4'd4;
        rs                       = 16'h00FE;
        rt                       = 64'h4444_3333_2222_1111;
        mem_write_ready          = 1'b0;
        core_state               = c_core_request;
        step();
        chk("w_state_req", 64'(lsu_state), 64'd1);
        core_state = c_core_other;
        for (int b = 0; b < 4; b++) begin
            step();
            chk($sformatf("w%0d_valid", b), 64'(mem_write_valid), 64'd1);
            chk($sformatf("w%0d_addr", b),  64'(mem_write_address), 64'(exp_waddr[b]));
            chk($sformatf("w%0d_data", b),  64'(mem_write_data), 64'(exp_wdata[b]));
            chk($sformatf("w%0d_rvalid", b), 64'(mem_read_valid), 64'd0);
            step();
            chk($sformatf("w%0d_valid_hold", b), 64'(mem_write_valid), 64'd1);
            mem_write_ready = 1'b1;
            step();
            chk($sformatf("w%0d_valid_gap", b), 64'(mem_write_valid), 64'd0);
            mem_write_ready = 1'b0;
            if (b < 3) chk($sformatf("w%0d_state_req", b), 64'(lsu_state), 64'd1);
        end
        chk("w_done", 64'(lsu_state), 64'd3);
        chk("w_err",  64'(lsu_error), 64'd0);
        chk("w_out_untouched", lsu_out, 64'h0000_0000_0000_4000);
        finish_access("w_idle");

        // ---------------- length zero and clamp ----------------
        run_read(4'd0, 16'h0020, "len0_done", beats);
        chk("len0_beats", 64'(beats), 64'd1);
        chk("len0_out", lsu_out, 64'h0000_0000_0000_A020);
        finish_access("len0_idle");

        run_read(4'd15, 16'h0030, "len15_done", beats);
        chk("len15_beats", 64'(beats), 64'd4);
        chk("len15_out", lsu_out, 64'hA033_A032_A031_A030);
        finish_access("len15_idle");

        // ---------------- watchdog timeout ----------------
        decoded_mem_read_enable = 1'b1;
        decoded_vec_len         = 4'd2;
        rs                      = 16'h0040;
        mem_read_ready          = 1'b0;
        core_state              = c_core_request;
        step();
        core_state = c_core_other;
        step();                                   // valid rises here
        chk("to_rvalid", 64'(mem_read_valid), 64'd1);
        chk("to_raddr",  64'(mem_read_address), 64'h40);
        repeat (TIMEOUT_CYCLES - 1) step();
        chk("to_rvalid_hold", 64'(mem_read_valid), 64'd1);
        chk("to_state_wait",  64'(lsu_state), 64'd2);
        step();                                   // 8th edge after valid
        chk("to_rvalid_drop", 64'(mem_read_valid), 64'd0);
        chk("to_done",        64'(lsu_state), 64'd3);
        chk("to_err",         64'(lsu_error), 64'd1);
        chk("to_out",         lsu_out, 64'hA033_A032_A031_A030);
        finish_access("to_idle");
        chk("to_err_hold", 64'(lsu_error), 64'd1);

        // ---------------- priority and enable stall ----------------
        decoded_mem_read_enable  = 1'b1;
        decoded_mem_write_enable = 1'b1;
        decoded_vec_len          = 4'd2;
        rs                       = 16'h0050;
        mem_read_ready           = 1'b0;
        core_state               = c_core_request;
        step();
        chk("pr_err_clear", 64'(lsu_error), 64'd0);
        core_state = c_core_other;
        step();
        chk("pr_rvalid", 64'(mem_read_valid), 64'd1);
        chk("pr_wvalid", 64'(mem_write_valid), 64'd0);
        chk("pr_raddr",  64'(mem_read_address), 64'h50);
        enable         = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        repeat (5) step();
        chk("st_state",  64'(lsu_state), 64'd2);
        chk("st_rvalid", 64'(mem_read_valid), 64'd1);
        chk("st_out",    lsu_out, 64'hA033_A032_A031_A030);
        enable         = 1'b1;
        mem_read_ready = 1'b0;
        repeat (TIMEOUT_CYCLES - 1) step();
        chk("st_wd_frozen_state", 64'(lsu_state), 64'd2);
        chk("st_wd_frozen_err",   64'(lsu_error), 64'd0);
        chk("st_wd_frozen_valid", 64'(mem_read_valid), 64'd1);
        mem_read_ready = 1'b1;
        model_data();
        step();
        chk("pr_b0_state", 64'(lsu_state), 64'd1);
        chk("pr_b0_valid", 64'(mem_read_valid), 64'd0);
        step();
        chk("pr_b1_rvalid", 64'(mem_read_valid), 64'd1);
        chk("pr_b1_wvalid", 64'(mem_write_valid), 64'd0);
        chk("pr_b1_raddr",  64'(mem_read_address), 64'h51);
        model_data();
        step();
        chk("pr_done", 64'(lsu_state), 64'd3);
        chk("pr_out",  lsu_out, 64'hA033_A032_A051_A050);
        chk("pr_err",  64'(lsu_error), 64'd0);
        finish_access("pr_idle");

        // ---------------- async reset mid-access ----------------
        decoded_mem_read_enable = 1'b1;
        decoded_vec_len         = 4'd4;
        rs                      = 16'h0060;
        mem_read_ready          = 1'b1;
        core_state              = c_core_request;
        step();
        core_state = c_core_other;
        model_data();
        step();                                   // beat 0 waiting
        model_data();
        step();                                   // beat 0 accepted
        mem_read_ready = 1'b0;
        step();                                   // beat 1 waiting
        chk("ar_rvalid", 64'(mem_read_valid), 64'd1);
        chk("ar_raddr",  64'(mem_read_address), 64'h61);
        #2 reset = 1'b1;
        #1;
        chk("ar_state",  64'(lsu_state), 64'd0);
        chk("ar_rvalid_async", 64'(mem_read_valid), 64'd0);
        chk("ar_raddr_clr", 64'(mem_read_address), 64'd0);
        chk("ar_out",    lsu_out, 64'd0);
        chk("ar_err",    64'(lsu_error), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("ar_idle_after", 64'(lsu_state), 64'd0);
        decoded_vec_len = 4'd1;
        rs              = 16'h0070;
        mem_read_ready  = 1'b1;
        core_state      = c_core_request;
        step();
        chk("ar2_state_req", 64'(lsu_state), 64'd1);
        core_state = c_core_other;
        step();
        chk("ar2_raddr", 64'(mem_read_address), 64'h70);
        model_data();
        step();
        chk("ar2_out", lsu_out, 64'h0000_0000_0000_A070);
        finish_access("ar2_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
